// File: rtl/gtpblkfifo.sv
// gtpblkfifo: packs a 16-bit GTP block stream into 32-bit Dwords and exposes only whole, committed blocks to the reader.
module gtpblkfifo #(
  parameter int MBITS = 13,
  parameter int LBITS = 9,
  parameter int TMO   = 255,
  parameter int CBITS = 16
) (
  input  logic             gtp_clk,
  input  logic             rst,
  input  logic [15:0]      gtp_dat,
  input  logic             gtp_vld,
  input  logic             give,
  output logic [31:0]      data,
  output logic             have,
  output logic             empty,
  output logic [MBITS-1:0] level,
  output logic             missed,
  output logic             err_ovr,
  output logic             err_undr,
  output logic             err_tmo,
  output logic [CBITS-1:0] missed_cnt
);
  localparam int TW = TMO > 0 ? $clog2(TMO + 1) : 1;
  localparam int W = MBITS + LBITS;
  localparam logic [TW-1:0] TLAST = TW'(TMO > 0 ? TMO - 1 : 0);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t state;
  logic [31:0] mem [2**MBITS];
  logic [31:0] wd, rdata;
  logic [MBITS-1:0] waddr, waddrb, raddr, ra_next, wa, free;
  logic [LBITS-1:0] rem, len;
  logic [15:0] low;
  logic [TW-1:0] timer;
  logic expect_cw, cw, dw, fits, we, last, zero_len;
  // a header always sizes against the committed pointer, so a CW cutting a block short sees the freed space
  assign cw = gtp_vld & gtp_dat[15];
  assign dw = gtp_vld & ~gtp_dat[15];
  assign len = LBITS'(gtp_dat[LBITS-1:1]) + LBITS'(1);
  assign free = ~(waddrb - raddr);
  assign fits = W'(free) >= W'(len);
  assign zero_len = ~|gtp_dat[LBITS-1:0];
  assign last = rem == LBITS'(1);
  assign we = (cw & fits & zero_len) | (dw & (state == HI)) | (dw & (state == LO) & last);
  assign wa = cw ? waddrb : waddr;
  assign wd = (cw | (state == LO)) ? {16'h8000, gtp_dat} : {1'b0, gtp_dat[14:0], low};
  assign have = give & (raddr != waddrb);
  assign ra_next = have ? raddr + 1'b1 : raddr;
  assign data = have ? rdata : '0;
  assign empty = raddr == waddr;
  assign level = waddrb - raddr;
  // read port is prefetched one Dword ahead, with a bypass for a write landing on that slot
  always_ff @(posedge gtp_clk) begin
    if (we) mem[wa] <= wd;
    rdata <= (we && wa == ra_next) ? wd : mem[ra_next];
  end
  always_ff @(posedge gtp_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      waddr <= '0;
      waddrb <= '0;
      raddr <= '0;
      timer <= '0;
      rem <= '0;
      low <= '0;
      expect_cw <= 1'b0;
      missed_cnt <= '0;
      {missed, err_ovr, err_undr, err_tmo} <= '0;
    end else begin
      {missed, err_ovr, err_undr, err_tmo} <= '0;
      if (have) raddr <= raddr + 1'b1;
      if (cw) begin
        err_undr <= state != IDLE;
        expect_cw <= 1'b0;
        timer <= '0;
        state <= IDLE;
        waddr <= waddrb;
        if (!fits) begin
          missed <= 1'b1;
          if (~&missed_cnt) missed_cnt <= missed_cnt + 1'b1;
        end else if (zero_len) begin
          waddr <= waddrb + 1'b1;
          waddrb <= waddrb + 1'b1;
          expect_cw <= 1'b1;
        end else begin
          low <= gtp_dat;
          rem <= gtp_dat[LBITS-1:0];
          state <= HI;
        end
      end else if (gtp_vld) begin
        timer <= '0;
        if (state == IDLE) begin
          err_ovr <= expect_cw;
          expect_cw <= 1'b0;
        end else if (state == HI || last) begin
          waddr <= waddr + 1'b1;
          rem <= rem - 1'b1;
          state <= last ? IDLE : LO;
          if (last) begin
            waddrb <= waddr + 1'b1;
            expect_cw <= 1'b1;
          end
        end else begin
          low <= gtp_dat;
          rem <= rem - 1'b1;
          state <= HI;
        end
      end else if (state != IDLE && TMO != 0) begin
        timer <= timer + 1'b1;
        if (timer == TLAST) begin
          err_tmo <= 1'b1;
          waddr <= waddrb;
          state <= IDLE;
          timer <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_gtpblkfifo.sv
// tb_gtpblkfifo: directed and random stimulus against a block-level queue model of the packing FIFO.
module tb_gtpblkfifo;
  logic clk = 0, rst = 1, vld = 0, give = 0;
  logic [15:0] dat = '0;
  logic [31:0] data;
  logic have, empty, missed, err_ovr, err_undr, err_tmo;
  logic [3:0] level, missed_cnt;
  int ncmp = 0, nfail = 0;
  logic [31:0] q[$];
  logic [15:0] blk[$];
  int need, idle, mcnt;
  bit inblk, exp_cw, p_miss, p_ovr, p_undr, p_tmo;

  always #5 clk = ~clk;

  gtpblkfifo #(.MBITS(4), .LBITS(9), .TMO(8), .CBITS(4)) dut (
    .gtp_clk(clk), .rst(rst), .gtp_dat(dat), .gtp_vld(vld), .give(give),
    .data(data), .have(have), .empty(empty), .level(level), .missed(missed),
    .err_ovr(err_ovr), .err_undr(err_undr), .err_tmo(err_tmo), .missed_cnt(missed_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete(); blk.delete();
    inblk = 0; exp_cw = 0; idle = 0; mcnt = 0; need = 0;
    {p_miss, p_ovr, p_undr, p_tmo} = '0;
  endtask

  task automatic commit();
    for (int i = 0; i < blk.size(); i += 2)
      q.push_back(i + 1 < blk.size() ? {blk[i+1] & 16'h7fff, blk[i]} : {16'h8000, blk[i]});
    blk.delete();
    inblk = 0;
    exp_cw = 1;
  endtask

  task automatic check_outputs();
    int qs = q.size();
    bit hv = give && qs > 0;
    chk("have", have, hv);
    chk("data", data, hv ? q[0] : 32'h0);
    chk("level", level, qs);
    chk("empty", empty, qs == 0 && !(inblk && blk.size() >= 2));
    chk("missed", missed, p_miss);
    chk("err_ovr", err_ovr, p_ovr);
    chk("err_undr", err_undr, p_undr);
    chk("err_tmo", err_tmo, p_tmo);
    chk("missed_cnt", missed_cnt, mcnt);
  endtask

  task automatic model_step();
    int qs = q.size();
    int len;
    {p_miss, p_ovr, p_undr, p_tmo} = '0;
    if (give && qs > 0) void'(q.pop_front());
    if (vld && dat[15]) begin
      p_undr = inblk;
      inblk = 0; blk.delete(); exp_cw = 0; idle = 0;
      len = int'(dat[8:1]) + 1;
      if (15 - qs >= len) begin
        blk.push_back(dat);
        need = int'(dat[8:0]);
        inblk = 1;
        if (need == 0) commit();
      end else begin
        p_miss = 1;
        if (mcnt < 15) mcnt++;
      end
    end else if (vld) begin
      idle = 0;
      if (inblk) begin
        blk.push_back(dat);
        if (blk.size() == need + 1) commit();
      end else if (exp_cw) begin
        p_ovr = 1;
        exp_cw = 0;
      end
    end else if (inblk) begin
      idle++;
      if (idle == 8) begin
        p_tmo = 1; inblk = 0; blk.delete(); exp_cw = 0; idle = 0;
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] d, input bit g);
    vld = v; dat = d; give = g;
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit g);
    for (int i = 0; i < n; i++) cyc(0, 16'h0, g);
  endtask

  task automatic block(input logic [15:0] cw, input int n);
    cyc(1, cw, 0);
    for (int i = 0; i < n; i++) cyc(1, {1'b0, 15'($urandom)}, 0);
  endtask

  task automatic do_reset();
    vld = 0; give = 1;
    #2 rst = 1;
    #1 model_reset();
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_have", have, 0);
    chk("rst_data", data, 0);
    chk("rst_mcnt", missed_cnt, 0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int vp;
    bit v;
    logic [15:0] d;
    model_reset();
    @(posedge clk);
    #1 do_reset();
    idle_cycles(2, 1);
    cyc(1, 16'h8003, 0); cyc(1, 16'h1111, 0); cyc(1, 16'h2222, 0); cyc(1, 16'h3333, 0);
    idle_cycles(1, 0);
    give = 1;
    #1 chk("blk3_level", level, 2);
    chk("blk3_d0", data, 32'h1111_8003);
    idle_cycles(3, 1);
    chk("drain_level", level, 0);
    cyc(1, 16'h8002, 0); cyc(1, 16'h0aaa, 0); cyc(1, 16'h0bbb, 0);
    idle_cycles(1, 1);
    #1 chk("blk2_d1", data, 32'h8000_0bbb);
    idle_cycles(2, 1);
    for (int i = 0; i < 7; i++) block(16'h8003, 3);
    cyc(1, 16'h8005, 0);
    #1 chk("fill_missed", missed, 1);
    chk("fill_mcnt", missed_cnt, 1);
    chk("fill_level", level, 14);
    cyc(1, 16'h8000, 0);
    idle_cycles(17, 1);
    block(16'h8009, 3);
    cyc(1, 16'h8001, 0);
    #1 chk("undr_pulse", err_undr, 1);
    cyc(1, 16'h0ccc, 0);
    idle_cycles(1, 0);
    give = 1;
    #1 chk("undr_d0", data, 32'h0ccc_8001);
    idle_cycles(2, 1);
    block(16'h8009, 2);
    idle_cycles(8, 0);
    #1 chk("tmo_pulse", err_tmo, 1);
    chk("tmo_level", level, 0);
    block(16'h8001, 1);
    cyc(1, 16'h0123, 0);
    #1 chk("ovr_pulse", err_ovr, 1);
    idle_cycles(2, 1);
    block(16'h8005, 2);
    do_reset();
    block(16'h8001, 1);
    idle_cycles(1, 0);
    #1 chk("post_rst_level", level, 1);
    idle_cycles(2, 1);
    for (int i = 0; i < 15; i++) cyc(1, 16'h8000, 0);
    for (int i = 0; i < 16; i++) cyc(1, 16'h8000, 0);
    #1 chk("mcnt_sat", missed_cnt, 15);
    idle_cycles(17, 1);
    for (int i = 0; i < 1500; i++) begin
      vp = (i / 150) % 3 == 0 ? 90 : (i / 150) % 3 == 1 ? 60 : 12;
      v = $urandom_range(99) < vp;
      if ($urandom_range(99) < 15) begin
        d = {1'b1, 6'($urandom), 9'($urandom_range(99) < 5 ? 40 : $urandom_range(12))};
      end else begin
        d = {1'b0, 15'($urandom)};
      end
      cyc(v, d, $urandom_range(99) < 35);
    end
    idle_cycles(20, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
